// File: rtl/solar_scan_sched_if.sv
// rtl/solar_scan_sched_if.sv - analog mux / converter handshake and captured-sample signals
interface solar_scan_sched_if #(
    parameter int DW = 10,
    parameter int CW = 2
);
    logic [CW-1:0] mux_sel_o;
    logic          conv_start_o;
    logic          conv_done_i;
    logic [DW-1:0] conv_data_i;
    logic          smp_valid_o;
    logic [CW-1:0] smp_ch_o;
    logic [DW-1:0] smp_data_o;

    modport master (
        output mux_sel_o, conv_start_o, smp_valid_o, smp_ch_o, smp_data_o,
        input  conv_done_i, conv_data_i
    );

    modport slave (
        input  mux_sel_o, conv_start_o, smp_valid_o, smp_ch_o, smp_data_o,
        output conv_done_i, conv_data_i
    );
endinterface

// File: rtl/solar_scan_sched.sv
// rtl/solar_scan_sched.sv - round-robin sensor scan: settle, convert, capture, flag faults/timeouts
module solar_scan_sched #(
    parameter int NCH     = 4,
    parameter int DW      = 10,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 255,
    parameter int PERIOD  = 1000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  enable_i,
    input  logic [DW-1:0]         thresh_i,
    solar_scan_sched_if.master    conv,
    output logic [NCH-1:0]        fault_o,
    output logic [NCH-1:0]        timeout_o,
    output logic                  scan_done_o,
    output logic                  overrun_o,
    output logic                  busy_o
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam int PW   = $clog2(PERIOD + 1);

    localparam logic [CNTW-1:0] SETTLE_LD  = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] TIMEOUT_LD = CNTW'(TIMEOUT - 1);
    localparam logic [PW-1:0]   PERIOD_LD  = PW'(PERIOD - 1);
    localparam logic [CW-1:0]   LAST_CH    = CW'(NCH - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_NEXT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   per_q, per_d;
    logic            overrun_q, overrun_d;
    logic [NCH-1:0]  fault_q, fault_d;
    logic [NCH-1:0]  timeout_q, timeout_d;
    logic            smp_valid_q, smp_valid_d;
    logic [CW-1:0]   smp_ch_q, smp_ch_d;
    logic [DW-1:0]   smp_data_q, smp_data_d;
    logic            tick;

    assign tick = enable_i && (per_q == '0);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            per_q       <= '0;
            overrun_q   <= 1'b0;
            fault_q     <= '0;
            timeout_q   <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            overrun_q   <= overrun_d;
            fault_q     <= fault_d;
            timeout_q   <= timeout_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_data_q  <= smp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        overrun_d   = overrun_q;
        fault_d     = fault_q;
        timeout_d   = timeout_q;
        smp_valid_d = 1'b0;
        smp_ch_d    = smp_ch_q;
        smp_data_d  = smp_data_q;

        if (!enable_i) begin
            // Disable abandons any scan; the fault/timeout history survives.
            state_d   = S_IDLE;
            ch_d      = '0;
            cnt_d     = '0;
            per_d     = '0;
            overrun_d = 1'b0;
        end else begin
            per_d = tick ? PERIOD_LD : per_q - PW'(1);
            if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        ch_d    = '0;
                        cnt_d   = SETTLE_LD;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) state_d = S_START;
                    else             cnt_d   = cnt_q - CNTW'(1);
                end
                S_START: begin
                    cnt_d   = TIMEOUT_LD;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A response on the final wait cycle still counts as answered.
                    if (conv.conv_done_i) begin
                        smp_valid_d     = 1'b1;
                        smp_ch_d        = ch_q;
                        smp_data_d      = conv.conv_data_i;
                        fault_d[ch_q]   = (conv.conv_data_i < thresh_i);
                        timeout_d[ch_q] = 1'b0;
                        state_d         = S_NEXT;
                    end else if (cnt_q == '0) begin
                        timeout_d[ch_q] = 1'b1;
                        state_d         = S_NEXT;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                S_NEXT: begin
                    if (ch_q == LAST_CH) begin
                        ch_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        ch_d    = ch_q + CW'(1);
                        cnt_d   = SETTLE_LD;
                        state_d = S_SETTLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign conv.mux_sel_o    = ch_q;
    assign conv.conv_start_o = enable_i && (state_q == S_START);
    assign conv.smp_valid_o  = smp_valid_q;
    assign conv.smp_ch_o     = smp_ch_q;
    assign conv.smp_data_o   = smp_data_q;
    assign scan_done_o       = enable_i && (state_q == S_NEXT) && (ch_q == LAST_CH);
    assign fault_o           = fault_q;
    assign timeout_o         = timeout_q;
    assign overrun_o         = overrun_q;
    assign busy_o            = (state_q != S_IDLE);
endmodule

// File: doc/solar_scan_sched.md
Name: solar_scan_sched

Overview:
- Round-robin acquisition scheduler for the solar monitor's panel sensor channels (string voltage/current, irradiance, temperature).
- On every scan period it steps an external analog mux through NCH channels and waits a settle time on each. It then fires a conversion request, captures the converter result and flags under-threshold or non-responding channels.
- It sits between the user_proj_solar core logic and the converter interface on the GPIO pins, all in the wb_clk_i domain.

Parameters:
- NCH, 4: number of sensor channels scanned, 2..16.
- DW, 10: conversion result width.
- SETTLE, 8: cycles mux_sel_o is held before conv_start_o, >=1.
- TIMEOUT, 255: max cycles waited for conv_done_i per channel, >=1.
- PERIOD, 1000: cycles between scan start ticks, >=2.

Ports:
- wb_clk_i  in  1  system clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  scheduler enable, level.
- thresh_i  in  DW  fault threshold, sampled at capture.
- conv_done_i  in  1  converter result valid, one-cycle pulse.
- conv_data_i  in  DW  converter result, valid with conv_done_i.
- mux_sel_o  out  CW=max(1,clog2(NCH))  analog mux channel select.
- conv_start_o  out  1  conversion request, one-cycle pulse.
- smp_valid_o  out  1  captured sample strobe, one cycle.
- smp_ch_o  out  CW  channel of smp_data_o.
- smp_data_o  out  DW  captured sample.
- fault_o  out  NCH  per-channel under-threshold flag.
- timeout_o  out  NCH  per-channel no-response flag.
- scan_done_o  out  1  one-cycle pulse after last channel handled.
- overrun_o  out  1  sticky: tick arrived while scan still busy.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, channel index 0, period counter 0.
- Period counter:
  - Counts only while enable_i=1.
  - When it is 0 it generates tick and reloads PERIOD-1; otherwise it decrements.
  - The first tick therefore occurs in the first enabled cycle.
  - Tick while IDLE starts a scan. Tick while busy sets overrun_o and is dropped.
- FSM states IDLE, SETTLE, START, WAIT, NEXT:
  - IDLE + tick: channel index := 0, settle counter := SETTLE-1, go to SETTLE. mux_sel_o reflects the new index from the same edge.
  - SETTLE: decrement; at 0 go to START.
  - START: conv_start_o=1 for exactly this cycle; wait counter := TIMEOUT-1; go to WAIT.
  - WAIT with conv_done_i=1:
    - Register conv_data_i into smp_data_o and channel into smp_ch_o; smp_valid_o=1 next cycle.
    - fault_o[ch] := (conv_data_i < thresh_i), unsigned; timeout_o[ch] := 0.
    - Go to NEXT.
  - WAIT with counter 0 and no conv_done_i: timeout_o[ch] := 1, fault_o[ch] unchanged, no smp_valid_o; go to NEXT.
  - WAIT otherwise: decrement.
  - conv_done_i and counter expiry in the same cycle: done wins.
  - conv_done_i outside WAIT is ignored.
  - NEXT, ch==NCH-1: scan_done_o=1 this cycle, index := 0, go to IDLE.
  - NEXT, otherwise: index := ch+1, settle counter := SETTLE-1, go to SETTLE.
- Latency:
  - tick at cycle T: SETTLE from T+1, conv_start_o at T+1+SETTLE.
  - conv_done_i at cycle W: smp_valid_o at W+1.
  - Next channel's SETTLE starts at W+2.
- Outputs: smp_ch_o/smp_data_o hold their value until the next capture. mux_sel_o is 0 in IDLE.
- enable_i=0:
  - Next edge forces IDLE and clears the period counter to 0; no pulses are issued.
  - A scan in progress is abandoned; fault_o/timeout_o keep their values.
  - overrun_o clears.
  - Re-enable restarts a scan from channel 0 immediately.
- Asynchronous reset mid-scan returns everything to reset values at once, with no pulse glitches after release.

Test Plan:
- Scan timing. Params NCH=4, SETTLE=8, TIMEOUT=16, PERIOD=200; enable at cycle 0; converter answers 3 cycles after each conv_start_o with data 0x200, thresh=0x100.
  - conv_start_o at cycles 9, 22, 35, 48.
  - smp_valid_o with ch 0..3 and data 0x200.
  - scan_done_o once; fault_o=0, timeout_o=0; next tick at cycle 200.
- Fault flag. Channel 2 returns 0x0FF, thresh=0x100 → fault_o=4'b0100. Next scan returns 0x100 → fault_o=0 (equal is not a fault).
- Timeout. Channel 1 never answers → timeout_o[1]=1 after 16 WAIT cycles, no smp_valid_o for ch1, and the scan continues to ch2. A later answered scan clears timeout_o[1].
- Overrun. PERIOD=40 with converter latency 10 → tick lands mid-scan, overrun_o=1 sticky. Toggling enable_i low for one cycle clears it.
- Abort. Deassert enable_i during WAIT on ch2 → IDLE next cycle, busy_o=0, no conv_start_o/scan_done_o, fault_o retained. Re-enable → conv_start_o for ch0 at enable+9.
- Reset. Assert wb_rst_ni low during SETTLE → all outputs 0 asynchronously. Release with enable_i=1 → first tick in the first clocked cycle.
